ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
Initiator/sequencer for the 4x8 register-file RAM port (adrs, din, dout, rd, wr).
- Accepts single and burst read/write/fill commands over a valid/ready command channel.
- Drives the RAM's rd/wr/adrs/din strobes.
- Returns read data over a valid/ready response channel with backpressure.
- Sits between the core's load/store logic and the RAM; it is the only master of the RAM port.

Parameters:
DATA_W, 8, data width (RAM word width)
ADRS_W, 2, RAM address width; depth = 2**ADRS_W = 4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  2  00 READ, 01 WRITE, 10 FILL, 11 READ_BURST
cmd_adrs  in  ADRS_W  start address
cmd_len  in  ADRS_W  word count minus 1 (FILL/READ_BURST only; forced 0 for READ/WRITE)
cmd_data  in  DATA_W  write/fill data
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer accepts rsp_data
rsp_data  out  DATA_W  read data, held stable while rsp_valid=1
busy  out  1  state != IDLE
mem_adrs  out  ADRS_W  to RAM adrs
mem_wdata  out  DATA_W  to RAM din
mem_rdata  in  DATA_W  from RAM dout (combinational RAM read)
mem_rd  out  1  to RAM rd
mem_wr  out  1  to RAM wr

Behaviour:
- Reset values (rst=0): state=IDLE, rsp_valid=0, rsp_data=0, mem_rd=0, mem_wr=0, mem_adrs=0, mem_wdata=0, busy=0, cmd_ready=1. Reset is asynchronous and takes effect immediately, including mid-burst. mem_wr drops at once; no partial state survives.
- Registered state: state, cur_adrs, remaining count, wdata, op.
- mem_* outputs decode from registers only; no combinational path from cmd_* or rsp_ready.
- States:
  - IDLE: cmd_ready=1. On cmd_valid=1, latch the command and set cnt=cmd_len (0 for READ/WRITE). WRITE/FILL go to WR; READ/READ_BURST go to RD.
  - WR: mem_wr=1, mem_adrs=cur_adrs, mem_wdata=wdata. The RAM captures the word at the end of this cycle. If cnt=0, go to IDLE. Otherwise cur_adrs+1, cnt-1, stay in WR. Rate: 1 word/cycle.
  - RD: mem_rd=1, mem_adrs=cur_adrs. At the clock edge, rsp_data<=mem_rdata and rsp_valid<=1; go to RSP.
  - RSP: mem_rd=0, rsp_valid=1, rsp_data held. On rsp_ready=1:
    - if cnt=0, clear rsp_valid and go to IDLE;
    - otherwise clear rsp_valid, cur_adrs+1, cnt-1, go to RD.
    - With rsp_ready held low, stays in RSP indefinitely.
- Latency, with the command accepted in cycle 0:
  - WRITE: mem_wr in cycle 1; RAM updated at the end of cycle 1; cmd_ready=1 again in cycle 2.
  - READ: mem_rd in cycle 1; rsp_valid in cycle 2.
  - READ_BURST: 2 cycles/word with rsp_ready held high.
- Address arithmetic is modulo 2**ADRS_W. Bursts wrap 3->0. A length-4 burst from any start touches every word exactly once.
- cmd_valid while busy: ignored (cmd_ready=0); the initiator must hold the command.
- cmd_valid and the last rsp handshake in the same cycle: the command is not accepted until the next cycle (IDLE is reached first).
- mem_rd and mem_wr are never high together. Both are 0 in IDLE and RSP.
- mem_adrs/mem_wdata hold their last values outside WR/RD.

Optional Feature:
RAM_CTRL_WR_ACK_EN
- Defined: after the last WR cycle of a WRITE/FILL, go to RSP with rsp_valid=1 and rsp_data = words written (zero-extended: 1..4). Return to IDLE on rsp_ready.
- Undefined: WRITE/FILL return directly to IDLE and produce no response.

Test Plan:
1. Reset mid-FILL (adrs 0, len 3, data 0x5A), rst low in 2nd WR cycle -> mem_wr=0 immediately, busy=0, cmd_ready=1; RAM word 0 = 0x5A, words 2,3 untouched.
2. WRITE adrs 2 data 0xA5, then READ adrs 2 -> mem_wr=1 exactly one cycle with mem_adrs=2; READ returns rsp_data=0xA5 two cycles after acceptance.
3. FILL adrs 3 len 3 data 0x3C -> mem_wr high 4 consecutive cycles, adrs sequence 3,0,1,2; all four RAM words = 0x3C.
4. Preload RAM 0x11,0x22,0x33,0x44; READ_BURST adrs 1 len 2 with rsp_ready low for 3 cycles on the first word -> rsp_data=0x22 held stable and mem_rd=0 while stalled; then 0x33, 0x44; busy=0 after the 3rd handshake.
5. cmd_valid held with WRITE adrs 0 data 0xFF during a READ_BURST -> not accepted until IDLE; RAM word 0 unchanged until then; exactly one write occurs.
6. With RAM_CTRL_WR_ACK_EN: FILL len 1 -> rsp_valid with rsp_data=0x02 after the 2nd write. Without the macro: no rsp_valid pulse.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: single master of the 4x8 register-file RAM port.
// Sequences single and burst READ / WRITE / FILL / READ_BURST commands taken
// from a valid/ready command channel. Read data goes back over a valid/ready
// response channel that honours backpressure.
// Optional feature macro: RAM_CTRL_WR_ACK_EN. When it is defined, every
// WRITE/FILL ends with a response that carries the number of words written.
module ram_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADRS_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADRS_W-1:0] cmd_adrs,
    input  logic [ADRS_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADRS_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RSP
    } state_t;

    state_t              state_q, state_d;
    logic [ADRS_W-1:0]   adrs_q, adrs_d;
    logic [ADRS_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
`ifdef RAM_CTRL_WR_ACK_EN
    // Original burst length. It is kept so the write acknowledge can report the word count.
    logic [ADRS_W-1:0]   len_q, len_d;
`endif

    // State and datapath registers; the asynchronous reset clears everything so that no partial burst survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            adrs_q      <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef RAM_CTRL_WR_ACK_EN
            len_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            adrs_q      <= adrs_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef RAM_CTRL_WR_ACK_EN
            len_q       <= len_d;
`endif
        end
    end

    // Next-state logic: latches commands, walks the bursts and runs the response handshake.
    always_comb begin
        state_d     = state_q;
        adrs_d      = adrs_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef RAM_CTRL_WR_ACK_EN
        len_d       = len_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    adrs_d = cmd_adrs;
                    // Only FILL and READ_BURST (op[1] set) use the length field.
                    cnt_d  = cmd_op[1] ? cmd_len : '0;
`ifdef RAM_CTRL_WR_ACK_EN
                    len_d  = cmd_op[1] ? cmd_len : '0;
`endif
                    if (cmd_op == OP_WRITE || cmd_op == OP_FILL) begin
                        // Write data is captured only for writes, so mem_wdata keeps its old value across reads.
                        wdata_d = cmd_data;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                if (cnt_q == '0) begin
`ifdef RAM_CTRL_WR_ACK_EN
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = DATA_W'(len_q) + DATA_W'(1);
                    state_d     = S_RSP;
`else
                    state_d     = S_IDLE;
`endif
                end else begin
                    adrs_d = adrs_q + ADRS_W'(1);
                    cnt_d  = cnt_q - ADRS_W'(1);
                end
            end
            S_RD: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // A write acknowledge always arrives with cnt_q == 0, so it returns to IDLE here too.
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        adrs_d  = adrs_q + ADRS_W'(1);
                        cnt_d   = cnt_q - ADRS_W'(1);
                        state_d = S_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The RAM strobes and handshake outputs are decoded from registers only.
    assign mem_wr    = (state_q == S_WR);
    assign mem_rd    = (state_q == S_RD);
    assign mem_adrs  = adrs_q;
    assign mem_wdata = wdata_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed testbench for ram_access_ctrl. It models the 4x8 RAM (synchronous
// write, combinational read) and checks the controller against hand-derived
// cycle-by-cycle values.
module tb_ram_access_ctrl;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_RDB   = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_adrs = 2'b00;
    logic [1:0] cmd_len = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy;
    logic [1:0] mem_adrs;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_rd;
    logic       mem_wr;

    logic [7:0] ram [4];
    logic       pre_we = 1'b0;
    logic [1:0] pre_adrs = 2'b00;
    logic [7:0] pre_data = 8'h00;
    int         wr_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         wr_base;

    ram_access_ctrl #(.DATA_W(8), .ADRS_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_adrs  (cmd_adrs),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .mem_adrs  (mem_adrs),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr)
    );

    always #5 clk = ~clk;

    // RAM model with a side port for preloading words while the controller is idle.
    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            ram[mem_adrs] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end else if (pre_we) begin
            ram[pre_adrs] <= pre_data;
        end
    end
    assign mem_rdata = ram[mem_adrs];

    // The two strobes must never be high together.
    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            assert (!(mem_rd === 1'b1 && mem_wr === 1'b1)) else begin
                n_err++;
                $error("FAIL rd_wr_excl observed rd=%0b wr=%0b required not both 1", mem_rd, mem_wr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] vals [4];
        vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3;
        for (int i = 0; i < 4; i++) begin
            pre_we   = 1'b1;
            pre_adrs = 2'(i);
            pre_data = vals[i];
            tick();
        end
        pre_we = 1'b0;
    endtask

    // Drives a command for one cycle. The caller must be sure that the controller is idle.
    task automatic issue(input logic [1:0] op, input logic [1:0] adrs,
                         input logic [1:0] len, input logic [7:0] data);
        cmd_op    = op;
        cmd_adrs  = adrs;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] fill_seq [4];
        fill_seq[0] = 2'd3; fill_seq[1] = 2'd0; fill_seq[2] = 2'd1; fill_seq[3] = 2'd2;

        #2 rst = 1'b0;
        preload(8'h01, 8'h02, 8'h03, 8'h04);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'h00);
        check("rst_mem_rd",    32'(mem_rd),    32'd0);
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_mem_adrs",  32'(mem_adrs),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h00);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b1;
        tick();

        // 1: reset asserted during the second WR cycle of a FILL
        issue(OP_FILL, 2'd0, 2'd3, 8'h5A);
        check("t1_wr_c1",   32'(mem_wr),    32'd1);
        check("t1_adrs_c1", 32'(mem_adrs),  32'd0);
        check("t1_wd_c1",   32'(mem_wdata), 32'h5A);
        tick();
        check("t1_adrs_c2", 32'(mem_adrs),  32'd1);
        #2 rst = 1'b0;
        #1;
        check("t1_rst_wr",    32'(mem_wr),    32'd0);
        check("t1_rst_busy",  32'(busy),      32'd0);
        check("t1_rst_ready", 32'(cmd_ready), 32'd1);
        check("t1_rst_adrs",  32'(mem_adrs),  32'd0);
        tick();
        tick();
        check("t1_ram0", 32'(ram[0]), 32'h5A);
        check("t1_ram1", 32'(ram[1]), 32'h02);
        check("t1_ram2", 32'(ram[2]), 32'h03);
        check("t1_ram3", 32'(ram[3]), 32'h04);
        rst = 1'b1;
        tick();

        // 2: WRITE to address 2, then READ it back
        wr_base = wr_cnt;
        issue(OP_WRITE, 2'd2, 2'd3, 8'hA5);
        check("t2_wr_c1",   32'(mem_wr),    32'd1);
        check("t2_adrs_c1", 32'(mem_adrs),  32'd2);
        check("t2_wd_c1",   32'(mem_wdata), 32'hA5);
        tick();
        check("t2_wr_c2", 32'(mem_wr), 32'd0);
`ifdef RAM_CTRL_WR_ACK_EN
        check("t2_ack_valid", 32'(rsp_valid), 32'd1);
        check("t2_ack_data",  32'(rsp_data),  32'h01);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
        check("t2_ready_c2", 32'(cmd_ready), 32'd1);
        check("t2_ram2",     32'(ram[2]),    32'hA5);
        check("t2_wr_count", 32'(wr_cnt - wr_base), 32'd1);
        issue(OP_READ, 2'd2, 2'd3, 8'h00);
        check("t2_rd_c1",    32'(mem_rd),    32'd1);
        check("t2_rdadrs",   32'(mem_adrs),  32'd2);
        check("t2_rv_c1",    32'(rsp_valid), 32'd0);
        tick();
        check("t2_rv_c2",    32'(rsp_valid), 32'd1);
        check("t2_rdata_c2", 32'(rsp_data),  32'hA5);
        check("t2_rd_c2",    32'(mem_rd),    32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t2_rv_c3",   32'(rsp_valid), 32'd0);
        check("t2_busy_c3", 32'(busy),      32'd0);

        // 3: FILL of 4 words that wraps 3 -> 0
        wr_base = wr_cnt;
        issue(OP_FILL, 2'd3, 2'd3, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            check("t3_wr",   32'(mem_wr),   32'd1);
            check("t3_adrs", 32'(mem_adrs), 32'(fill_seq[i]));
            tick();
        end
        check("t3_wr_end", 32'(mem_wr), 32'd0);
`ifdef RAM_CTRL_WR_ACK_EN
        check("t3_ack_data", 32'(rsp_data), 32'h04);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
        check("t3_wr_count", 32'(wr_cnt - wr_base), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_ram", 32'(ram[i]), 32'h3C);

        // 4: READ_BURST with backpressure on the first word
        preload(8'h11, 8'h22, 8'h33, 8'h44);
        issue(OP_RDB, 2'd1, 2'd2, 8'h00);
        check("t4_rd_c1",   32'(mem_rd),   32'd1);
        check("t4_adrs_c1", 32'(mem_adrs), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_stall_rv", 32'(rsp_valid), 32'd1);
            check("t4_stall_rd", 32'(rsp_data),  32'h22);
            check("t4_stall_mr", 32'(mem_rd),    32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("t4_rv_c5",   32'(rsp_valid), 32'd0);
        check("t4_adrs_c5", 32'(mem_adrs),  32'd2);
        tick();
        check("t4_rd_w2", 32'(rsp_data), 32'h33);
        tick();
        tick();
        check("t4_rv_w3", 32'(rsp_valid), 32'd1);
        check("t4_rd_w3", 32'(rsp_data),  32'h44);
        check("t4_busy_w3", 32'(busy),    32'd1);
        tick();
        rsp_ready = 1'b0;
        check("t4_busy_end", 32'(busy),      32'd0);
        check("t4_rv_end",   32'(rsp_valid), 32'd0);

        // 5: WRITE held on cmd_valid while a READ_BURST is running
        wr_base = wr_cnt;
        rsp_ready = 1'b1;
        issue(OP_RDB, 2'd2, 2'd1, 8'h00);
        cmd_op    = OP_WRITE;
        cmd_adrs  = 2'd0;
        cmd_len   = 2'd0;
        cmd_data  = 8'hFF;
        cmd_valid = 1'b1;
        check("t5_ready_c1", 32'(cmd_ready), 32'd0);
        tick();
        check("t5_ready_c2", 32'(cmd_ready), 32'd0);
        check("t5_rd_c2",    32'(rsp_data),  32'h33);
        tick();
        tick();
        check("t5_rd_c4",   32'(rsp_data), 32'h44);
        check("t5_ram0_c4", 32'(ram[0]),   32'h11);
        tick();
        check("t5_ready_c5", 32'(cmd_ready), 32'd1);
        check("t5_wr_c5",    32'(mem_wr),    32'd0);
        check("t5_ram0_c5",  32'(ram[0]),    32'h11);
        tick();
        cmd_valid = 1'b0;
        check("t5_wr_c6",   32'(mem_wr),    32'd1);
        check("t5_adrs_c6", 32'(mem_adrs),  32'd0);
        check("t5_wd_c6",   32'(mem_wdata), 32'hFF);
        tick();
        check("t5_ram0_c7", 32'(ram[0]), 32'hFF);
        tick();
        tick();
        rsp_ready = 1'b0;
        check("t5_wr_count", 32'(wr_cnt - wr_base), 32'd1);
        check("t5_busy_end", 32'(busy), 32'd0);

        // 6: FILL of two words, with or without the write acknowledge
        issue(OP_FILL, 2'd0, 2'd1, 8'h77);
        check("t6_rv_c1", 32'(rsp_valid), 32'd0);
        tick();
        check("t6_rv_c2", 32'(rsp_valid), 32'd0);
        tick();
`ifdef RAM_CTRL_WR_ACK_EN
        check("t6_ack_valid", 32'(rsp_valid), 32'd1);
        check("t6_ack_data",  32'(rsp_data),  32'h02);
        check("t6_ack_busy",  32'(busy),      32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t6_ack_clear", 32'(rsp_valid), 32'd0);
`else
        check("t6_no_rsp", 32'(rsp_valid), 32'd0);
`endif
        check("t6_busy_end", 32'(busy),   32'd0);
        check("t6_ram1",     32'(ram[1]), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
